// File: rtl/addsub_arbiter.sv
// Round-robin front end that lets two requesters share one external 4-bit
// adder/subtractor through a req/ack handshake with registered results.
module addsub_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0,
  input  logic             i_op0,
  input  logic [WIDTH-1:0] i_a0,
  input  logic [WIDTH-1:0] i_b0,
  input  logic             i_req1,
  input  logic             i_op1,
  input  logic [WIDTH-1:0] i_a1,
  input  logic [WIDTH-1:0] i_b1,
  output logic             o_ack0,
  output logic             o_ack1,
  output logic [WIDTH-1:0] o_res_S,
  output logic             o_res_Cout,
  output logic             o_res_V,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_add_A,
  output logic [WIDTH-1:0] o_add_B,
  output logic             o_add_C0,
  input  logic [WIDTH-1:0] i_add_S,
  input  logic             i_add_Cout,
  input  logic             i_add_V
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       r_state;
  logic             r_last;
  logic             r_gnt;
  logic             r_ack0;
  logic             r_ack1;
  logic [WIDTH-1:0] r_res_S;
  logic             r_res_Cout;
  logic             r_res_V;
  logic [WIDTH-1:0] r_add_A;
  logic [WIDTH-1:0] r_add_B;
  logic             r_add_C0;

  logic w_any;
  logic w_pick;

  // On a tie the requester that was not served last wins.
  assign w_any  = i_req0 | i_req1;
  assign w_pick = (i_req0 & i_req1) ? ~r_last : i_req1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_last     <= 1'b1;
      r_gnt      <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_res_S    <= '0;
      r_res_Cout <= 1'b0;
      r_res_V    <= 1'b0;
      r_add_A    <= '0;
      r_add_B    <= '0;
      r_add_C0   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt    <= w_pick;
            r_add_A  <= w_pick ? i_a1  : i_a0;
            r_add_B  <= w_pick ? i_b1  : i_b0;
            r_add_C0 <= w_pick ? i_op1 : i_op0;
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Shared adder is combinational; its outputs have settled by now.
          r_res_S    <= i_add_S;
          r_res_Cout <= i_add_Cout;
          r_res_V    <= i_add_V;
          r_ack0     <= ~r_gnt;
          r_ack1     <= r_gnt;
          r_last     <= r_gnt;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ack0     = r_ack0;
  assign o_ack1     = r_ack1;
  assign o_res_S    = r_res_S;
  assign o_res_Cout = r_res_Cout;
  assign o_res_V    = r_res_V;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_add_A    = r_add_A;
  assign o_add_B    = r_add_B;
  assign o_add_C0   = r_add_C0;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with an external adder model and a
// scoreboard queue drained by an independent ack monitor.
module tb_addsub_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, op0, req1, op1;
  logic [3:0] a0, b0, a1, b1;
  logic       ack0, ack1;
  logic [3:0] res_S;
  logic       res_Cout, res_V, busy;
  logic [3:0] add_A, add_B;
  logic       add_C0;
  logic [3:0] add_S;
  logic       add_Cout, add_V;

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic       op;
    logic [3:0] s;
    logic       cout;
    logic       v;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   ack_seen = 0;

  addsub_arbiter #(.WIDTH(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_op0(op0), .i_a0(a0), .i_b0(b0),
    .i_req1(req1), .i_op1(op1), .i_a1(a1), .i_b1(b1),
    .o_ack0(ack0), .o_ack1(ack1),
    .o_res_S(res_S), .o_res_Cout(res_Cout), .o_res_V(res_V),
    .o_busy(busy),
    .o_add_A(add_A), .o_add_B(add_B), .o_add_C0(add_C0),
    .i_add_S(add_S), .i_add_Cout(add_Cout), .i_add_V(add_V)
  );

  // External ripple-carry adder/subtractor: B is inverted when C0 = 1.
  logic [3:0] bx;
  logic [3:0] low_sum;
  always_comb begin
    bx                 = add_B ^ {4{add_C0}};
    {add_Cout, add_S}  = {1'b0, add_A} + {1'b0, bx} + {4'b0, add_C0};
    low_sum            = {1'b0, add_A[2:0]} + {1'b0, bx[2:0]} + {3'b0, add_C0};
    add_V              = low_sum[3] ^ add_Cout;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic id, input logic [3:0] a, input logic [3:0] b,
                      input logic op, input logic [3:0] s, input logic cout, input logic v);
    exp_t e;
    e.id = id; e.a = a; e.b = b; e.op = op; e.s = s; e.cout = cout; e.v = v;
    sb.push_back(e);
  endtask

  // Returns just after the negedge on which the n-th further ack was scored.
  task automatic wait_acks(input int n);
    int target;
    bit hit;
    target = ack_seen + n;
    hit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (ack_seen >= target) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check("ack_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: scores every ack against the queue head; during EXEC checks the
  // adder drive matches the operands captured at grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ack0 || ack1) begin
          check("ack_onehot", {31'b0, ack0 & ack1}, 32'd0);
          if (sb.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("ack_id",   {31'b0, ack1},     {31'b0, e.id});
            check("res_S",    {28'b0, res_S},    {28'b0, e.s});
            check("res_Cout", {31'b0, res_Cout}, {31'b0, e.cout});
            check("res_V",    {31'b0, res_V},    {31'b0, e.v});
            ack_seen++;
          end
        end else if (busy && sb.size() > 0) begin
          check("exec_add_A",  {28'b0, add_A},  {28'b0, sb[0].a});
          check("exec_add_B",  {28'b0, add_B},  {28'b0, sb[0].b});
          check("exec_add_C0", {31'b0, add_C0}, {31'b0, sb[0].op});
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req0 = 0; op0 = 0; a0 = 0; b0 = 0;
    req1 = 0; op1 = 0; a1 = 0; b1 = 0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {13'b0, ack0, ack1, res_S, res_Cout, res_V, busy, add_A, add_B, add_C0},
          32'd0);
    rst = 1'b0;

    // Single add from requester 0, with latency and busy profile.
    @(negedge clk);
    push(1'b0, 4'b0111, 4'b0101, 1'b0, 4'b1100, 1'b0, 1'b1);
    req0 = 1; op0 = 0; a0 = 4'b0111; b0 = 4'b0101;
    @(posedge clk); #1;
    req0 = 0;
    @(negedge clk);
    check("t1_exec_busy_ack", {30'b0, busy, ack0}, 32'b10);
    @(negedge clk);
    check("t1_resp_busy_ack", {30'b0, busy, ack0}, 32'b11);
    @(negedge clk);
    check("t1_idle_busy_ack", {30'b0, busy, ack0}, 32'b00);
    repeat (2) @(negedge clk);
    check("t1_result_hold", {28'b0, res_S}, {28'b0, 4'b1100});

    // Subtract from requester 1.
    push(1'b1, 4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b1, 1'b0);
    req1 = 1; op1 = 1; a1 = 4'b0101; b1 = 4'b0011;
    wait_acks(1);
    req1 = 0;
    @(negedge clk);

    // Both held: round-robin order 0, 1, 0.
    push(1'b0, 4'b0011, 4'b0001, 1'b0, 4'b0100, 1'b0, 1'b0);
    push(1'b1, 4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1);
    push(1'b0, 4'b0011, 4'b0001, 1'b0, 4'b0100, 1'b0, 1'b0);
    req0 = 1; op0 = 0; a0 = 4'b0011; b0 = 4'b0001;
    req1 = 1; op1 = 1; a1 = 4'b1000; b1 = 4'b0001;
    wait_acks(2);
    req1 = 0;
    wait_acks(1);
    req0 = 0;
    @(negedge clk);

    // Operand change after grant is ignored.
    push(1'b0, 4'b0010, 4'b0010, 1'b0, 4'b0100, 1'b0, 1'b0);
    req0 = 1; op0 = 0; a0 = 4'b0010; b0 = 4'b0010;
    @(posedge clk); #1;
    a0 = 4'b1111;
    req0 = 0;
    wait_acks(1);
    @(negedge clk);

    // Reset during EXEC aborts; then a tie goes to requester 0 again.
    req0 = 1; op0 = 1; a0 = 4'b0000; b0 = 4'b0001;
    @(posedge clk); #1;
    rst = 1'b1;
    req0 = 0;
    #2;
    check("abort_outputs",
          {13'b0, ack0, ack1, res_S, res_Cout, res_V, busy, add_A, add_B, add_C0},
          32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_ack", {30'b0, ack0, ack1}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    push(1'b0, 4'b0000, 4'b0001, 1'b1, 4'b1111, 1'b0, 1'b0);
    push(1'b1, 4'b0110, 4'b0011, 1'b0, 4'b1001, 1'b0, 1'b1);
    req0 = 1; op0 = 1; a0 = 4'b0000; b0 = 4'b0001;
    req1 = 1; op1 = 0; a1 = 4'b0110; b1 = 4'b0011;
    wait_acks(1);
    req0 = 0;
    wait_acks(1);
    req1 = 0;

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
